// File: rtl/ioctl_mem_loader.sv
// Multi-region HPS download loader: ioctl write beats -> small FIFO -> SDRAM toggle req/ack write port.
// Optional running checksum of written words is enabled by defining LOADER_CKSUM_EN.
module ioctl_mem_loader #(
  parameter int               DW        = 16,
  parameter int               AW        = 24,
  parameter int               NCH       = 2,
  parameter int               IDX_FIRST = 0,
  parameter logic [NCH*AW-1:0] CH_BASE  = '0,
  parameter int               DEPTH     = 4,
  localparam int              CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  input  logic          swap,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_be,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] chan,
  output logic [AW-1:0] size,
  output logic          overflow,
  output logic [15:0]   cksum,
  output logic [1:0]    dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  // Handshake: ioctl_wr is a one-cycle push, honoured only while ioctl_wait is low;
  // the memory port has a write outstanding whenever mem_req != mem_ack.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          dl_q, pend, pend_next, done_next, wait_next;
  logic [DW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, count_next;
  logic [AW-1:0] wptr;
  logic          rise, port_idle, full, push, pop, drop, start, ch_valid;
  logic [CW-1:0] ch_sel;
  logic [AW-1:0] base_sel, base_aligned;
  logic [DW-1:0] head;
  logic [15:0]   din_next;
  logic [1:0]    be_next;
  logic          unused_idx;

  assign unused_idx = ^ioctl_index[7:6];

  always_comb begin
    ch_valid = 1'b0;
    ch_sel   = '0;
    base_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(ioctl_index[5:0]) == IDX_FIRST + c) begin
        ch_valid = 1'b1;
        ch_sel   = CW'(c);
        base_sel = CH_BASE[c*AW +: AW];
      end
    end
  end

  // Word-wide downloads always start on an even byte address.
  assign base_aligned = base_sel & ~(STEP - AW'(1));

  assign rise      = ioctl_download & ~dl_q;
  assign port_idle = (mem_req == mem_ack);
  assign full      = (count == (PW+1)'(DEPTH));
  assign push      = (state == S_LOAD) && ioctl_wr && !full;
  assign drop      = (state == S_LOAD) && ioctl_wr && full;
  assign pop       = port_idle && (count != '0);
  assign head      = fifo_mem[rd_ptr];

  always_comb begin
    state_next = state;
    pend_next  = pend;
    done_next  = 1'b0;
    start      = 1'b0;
    case (state)
      S_IDLE: begin
        pend_next = 1'b0;
        if (ioctl_download && (rise || pend) && ch_valid) begin
          start      = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!ioctl_download) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // A download raised while draining is remembered and started on the IDLE cycle.
        if (rise) pend_next = 1'b1;
        else if (!ioctl_download) pend_next = 1'b0;
        if ((count == '0) && port_idle) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);
  assign wait_next  = (count_next >= (PW+1)'(DEPTH - 1)) ||
                      ((state_next != S_IDLE) && pend_next);

  if (DW == 16) begin : g_w16
    always_comb begin
      din_next = swap ? {head[7:0], head[15:8]} : head;
      be_next  = 2'b11;
    end
  end else begin : g_w8
    logic unused_swap;
    assign unused_swap = swap;
    always_comb begin
      din_next = {head, head};
      be_next  = wptr[0] ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= ioctl_dout;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      pend       <= 1'b0;
      done       <= 1'b0;
      ioctl_wait <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      wptr       <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_be     <= '0;
      mem_req    <= 1'b0;
      chan       <= '0;
      size       <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      dl_q       <= ioctl_download;
      pend       <= pend_next;
      done       <= done_next;
      ioctl_wait <= wait_next;
      count      <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        size   <= size + STEP;
      end
      if (drop) overflow <= 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        mem_addr <= wptr;
        mem_din  <= din_next;
        mem_be   <= be_next;
        mem_req  <= ~mem_req;
        wptr     <= wptr + STEP;
      end
      if (start) begin
        chan     <= ch_sel;
        wptr     <= base_aligned;
        size     <= '0;
        overflow <= 1'b0;
      end
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [15:0] cksum_q;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)   cksum_q <= '0;
    else if (start) cksum_q <= '0;
    else if (pop)   cksum_q <= cksum_q + {be_next[1] ? din_next[15:8] : 8'h00,
                                          be_next[0] ? din_next[7:0]  : 8'h00};
  end
  assign cksum = cksum_q;
`else
  assign cksum = 16'h0000;
`endif

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ioctl_mem_loader.sv
// Bench for ioctl_mem_loader: a 16-bit and an 8-bit instance share one host driver,
// each with its own memory responder and expected-write queue.
module tb_ioctl_mem_loader;
  localparam int AW    = 24;
  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_dout = 16'd0;
  logic        swap = 1'b0;

  logic        wait16, req16, ack16, busy16, done16, ovf16, chan16;
  logic [23:0] addr16, size16;
  logic [15:0] din16, ck16o;
  logic [1:0]  be16, st16;
  logic        wait8, req8, ack8, busy8, done8, ovf8, chan8;
  logic [23:0] addr8, size8;
  logic [15:0] din8, ck8o;
  logic [1:0]  be8, st8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [41:0] exp16_q[$];
  logic [41:0] exp8_q[$];
  logic [23:0] base16_tab [2] = '{24'h000000, 24'h100000};
  logic [23:0] base8_tab  [2] = '{24'h000000, 24'h000301};

  int          cur_ch, beat_n, max_lat, done16_cnt, done8_cnt;
  logic        cur_sw, hold_ack;
  logic [15:0] m_ck16, m_ck8;
  logic        seen16, seen8;
  int          lat16, lat8;

  ioctl_mem_loader #(.DW(16), .AW(AW), .NCH(2), .IDX_FIRST(0),
                     .CH_BASE({24'h100000, 24'h000000}), .DEPTH(DEPTH)) u16 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(wait16), .swap(swap), .mem_addr(addr16), .mem_din(din16),
    .mem_be(be16), .mem_req(req16), .mem_ack(ack16), .busy(busy16), .done(done16),
    .chan(chan16), .size(size16), .overflow(ovf16), .cksum(ck16o), .dbg_state(st16));

  ioctl_mem_loader #(.DW(8), .AW(AW), .NCH(2), .IDX_FIRST(0),
                     .CH_BASE({24'h000301, 24'h000000}), .DEPTH(DEPTH)) u8 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout[7:0]),
    .ioctl_wait(wait8), .swap(swap), .mem_addr(addr8), .mem_din(din8),
    .mem_be(be8), .mem_req(req8), .mem_ack(ack8), .busy(busy8), .done(done8),
    .chan(chan8), .size(size8), .overflow(ovf8), .cksum(ck8o), .dbg_state(st8));

  // Clock / reset
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responders: score each new request, ack after a random latency unless held.
  always @(negedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack16 = 1'b0; seen16 = 1'b0; lat16 = 0;
    end else if (req16 != seen16) begin
      seen16 = req16;
      if (exp16_q.size() == 0) check("wr16_unexpected", 64'(addr16), 64'hFFFFFFFF);
      else check("wr16", 64'({addr16, din16, be16}), 64'(exp16_q.pop_front()));
      lat16 = $urandom_range(0, max_lat);
    end else if (req16 != ack16 && !hold_ack) begin
      if (lat16 == 0) ack16 = req16;
      else lat16--;
    end
  end

  always @(negedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack8 = 1'b0; seen8 = 1'b0; lat8 = 0;
    end else if (req8 != seen8) begin
      seen8 = req8;
      if (exp8_q.size() == 0) check("wr8_unexpected", 64'(addr8), 64'hFFFFFFFF);
      else check("wr8", 64'({addr8, din8, be8}), 64'(exp8_q.pop_front()));
      lat8 = $urandom_range(0, max_lat);
    end else if (req8 != ack8 && !hold_ack) begin
      if (lat8 == 0) ack8 = req8;
      else lat8--;
    end
  end

  always @(negedge clk_sys) begin
    if (done16) begin done16_cnt++; check("done_busy16", 64'(busy16), 64'd0); end
    if (done8)  begin done8_cnt++;  check("done_busy8",  64'(busy8),  64'd0); end
  end

  // Reference model: write k of a download goes to base + k*bytes_per_beat.
  task automatic model_start(input int ch, input logic sw);
    cur_ch = ch; cur_sw = sw; beat_n = 0; m_ck16 = 16'h0; m_ck8 = 16'h0;
  endtask

  task automatic model_push(input logic [15:0] d);
    logic [23:0] a16, a8;
    logic [15:0] w16;
    logic [7:0]  b;
    a16 = base16_tab[cur_ch] + 24'(2 * beat_n);
    w16 = cur_sw ? {d[7:0], d[15:8]} : d;
    exp16_q.push_back({a16, w16, 2'b11});
    m_ck16 += w16;
    a8 = base8_tab[cur_ch] + 24'(beat_n);
    b  = d[7:0];
    exp8_q.push_back({a8, b, b, a8[0] ? 2'b10 : 2'b01});
    m_ck8 += a8[0] ? {b, 8'h00} : {8'h00, b};
    beat_n++;
  endtask

  // Driver tasks (entered and left on a negedge)
  task automatic start_dl(input int ch, input logic sw);
    ioctl_index = 8'(ch); swap = sw; ioctl_download = 1'b1;
    model_start(ch, sw);
    repeat (2) @(negedge clk_sys);
    check("chan16", 64'(chan16), 64'(ch[0]));
    check("chan8", 64'(chan8), 64'(ch[0]));
    check("ovf_clear16", 64'(ovf16), 64'd0);
    check("busy_load8", 64'(busy8), 64'd1);
  endtask

  task automatic put_beat(input logic [15:0] d);
    int t = 0;
    while ((wait16 || wait8) && t < 300) begin @(negedge clk_sys); t++; end
    if (t >= 300) check("wait_timeout", 64'd1, 64'd0);
    ioctl_wr = 1'b1; ioctl_dout = d;
    model_push(d);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  // Ignores ioctl_wait; with the port stalled the loader holds DEPTH queued plus one in flight.
  task automatic force_beat(input logic [15:0] d);
    ioctl_wr = 1'b1; ioctl_dout = d;
    if (beat_n < DEPTH + 1) model_push(d);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    int t = 0;
    int d16 = done16_cnt;
    int d8  = done8_cnt;
    logic [15:0] e16, e8;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    while ((busy16 || busy8) && t < 1000) begin @(negedge clk_sys); t++; end
    check("drain_timeout", 64'(t < 1000), 64'd1);
    @(negedge clk_sys);
    check("done16_once", 64'(done16_cnt - d16), 64'd1);
    check("done8_once", 64'(done8_cnt - d8), 64'd1);
    check("size16", 64'(size16), 64'(24'(2 * beat_n)));
    check("size8", 64'(size8), 64'(24'(beat_n)));
    check("pending16", 64'(exp16_q.size()), 64'd0);
    check("pending8", 64'(exp8_q.size()), 64'd0);
`ifdef LOADER_CKSUM_EN
    e16 = m_ck16; e8 = m_ck8;
`else
    e16 = 16'h0; e8 = 16'h0;
`endif
    check("cksum16", 64'(ck16o), 64'(e16));
    check("cksum8", 64'(ck8o), 64'(e8));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl16"}, 64'({wait16, req16, busy16, done16, ovf16, chan16}), 64'd0);
    check({tag, "_sz16"}, 64'({size16, addr16}), 64'd0);
    check({tag, "_dat16"}, 64'({din16, be16, ck16o}), 64'd0);
    check({tag, "_ctl8"}, 64'({wait8, req8, busy8, done8, ovf8, chan8}), 64'd0);
    check({tag, "_sz8"}, 64'({size8, addr8}), 64'd0);
    check({tag, "_dat8"}, 64'({din8, be8, ck8o}), 64'd0);
  endtask

  initial begin
    int t, d16, d8, n;
    max_lat = 0; hold_ack = 1'b0; done16_cnt = 0; done8_cnt = 0;
    model_start(0, 1'b0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Two word beats to region 1, plain and swapped
    start_dl(1, 1'b0); put_beat(16'h1234); put_beat(16'h5678); end_dl();
    start_dl(1, 1'b1); put_beat(16'h1234); put_beat(16'h5678); end_dl();
    // Three bytes to region 0 (8-bit lanes alternate)
    start_dl(0, 1'b0); put_beat(16'h11AA); put_beat(16'h22BB); put_beat(16'h33CC); end_dl();

    // Stalled port: backpressure, then forced writes overflow
    max_lat = 1;
    start_dl(1, 1'b0);
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) put_beat(16'($urandom));
    check("wait_full16", 64'(wait16), 64'd1);
    check("wait_full8", 64'(wait8), 64'd1);
    for (int i = 0; i < 3; i++) force_beat(16'($urandom));
    check("ovf16", 64'(ovf16), 64'd1);
    check("ovf8", 64'(ovf8), 64'd1);
    check("ovf_size16", 64'(size16), 64'(24'(2 * (DEPTH + 1))));
    check("ovf_size8", 64'(size8), 64'(24'(DEPTH + 1)));
    repeat (14) @(negedge clk_sys);
    hold_ack = 1'b0;
    end_dl();

    // Invalid index: nothing starts
    d16 = done16_cnt;
    ioctl_index = 8'd5; ioctl_download = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      check("inv_busy16", 64'(busy16), 64'd0);
    end
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("inv_busy8", 64'(busy8), 64'd0);
    check("inv_done16", 64'(done16_cnt - d16), 64'd0);

    // Reset in the middle of a load
    start_dl(0, 1'b0);
    hold_ack = 1'b1;
    put_beat(16'hA5A5); put_beat(16'h5A5A);
    repeat (2) @(negedge clk_sys);
    d16 = done16_cnt; d8 = done8_cnt;
    reset_n = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    check_all_zero("mid_reset");
    exp16_q.delete(); exp8_q.delete();
    hold_ack = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_no_done", 64'((done16_cnt - d16) + (done8_cnt - d8)), 64'd0);
    start_dl(1, 1'b0);
    for (int i = 0; i < 3; i++) put_beat(16'($urandom));
    end_dl();

    // New download raised while the previous one is still draining
    start_dl(0, 1'b0);
    hold_ack = 1'b1;
    for (int i = 0; i < 3; i++) put_beat(16'($urandom));
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    d16 = done16_cnt; d8 = done8_cnt;
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("pend_wait16", 64'(wait16), 64'd1);
    check("pend_wait8", 64'(wait8), 64'd1);
    check("pend_busy16", 64'(busy16), 64'd1);
    hold_ack = 1'b0;
    t = 0;
    while ((wait16 || wait8) && t < 500) begin @(negedge clk_sys); t++; end
    check("pend_timeout", 64'(t < 500), 64'd1);
    repeat (2) @(negedge clk_sys);
    check("pend_done16", 64'(done16_cnt - d16), 64'd1);
    check("pend_done8", 64'(done8_cnt - d8), 64'd1);
    check("pend_chan16", 64'(chan16), 64'd1);
    check("pend_busy8", 64'(busy8), 64'd1);
    model_start(1, 1'b0);
    put_beat(16'hBEEF); put_beat(16'hCAFE);
    end_dl();

    // Randomized downloads
    for (int k = 0; k < 8; k++) begin
      max_lat = $urandom_range(0, 3);
      start_dl($urandom_range(0, 1), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 10);
      for (int j = 0; j < n; j++) begin
        put_beat(16'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      end
      end_dl();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
